// File: rtl/area_prmter_mac_ctrl.sv
// area_prmter_mac_ctrl
// Streaming multiply-accumulate controller around an external pipelined
// 8x14 -> 22-bit multiplier. Operand pairs flow straight into the multiplier.
// A ce-gated tag pipeline follows each pair through the multiplier registers.
// Products are summed per burst, and each burst result is presented downstream
// with valid/ready back-pressure.

module area_prmter_mac_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_a,
  input  logic [13:0]      s_b,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             mul_ce,
  output logic [7:0]       mul_din0,
  output logic [13:0]      mul_din1,
  input  logic [21:0]      mul_dout,
  output logic [ACC_W-1:0] m_sum,
  output logic [CNT_W-1:0] m_count,
  output logic             m_overflow,
  output logic             m_valid,
  input  logic             m_ready
);

  logic               stall;
  logic [MUL_LAT-1:0] tag_valid;
  logic [MUL_LAT-1:0] tag_last;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sticky;
  logic               consume;
  logic               consume_last;
  logic [ACC_W:0]     sum_ext;
  logic               carry;
  logic [CNT_W-1:0]   cnt_next;

  // An unaccepted result freezes the whole datapath, including the multiplier.
  // Freezing everything means no in-flight product is lost or duplicated.
  assign stall    = m_valid & ~m_ready;
  assign mul_ce   = ~stall;
  assign s_ready  = ~stall;
  assign mul_din0 = s_a;
  assign mul_din1 = s_b;

  // The product at the multiplier output belongs to the oldest tag.
  // It is consumed only on an edge where the pipeline advances.
  always_comb begin
    consume      = mul_ce & tag_valid[MUL_LAT-1];
    consume_last = consume & tag_last[MUL_LAT-1];
    sum_ext      = {1'b0, acc} + {{(ACC_W-21){1'b0}}, mul_dout};
    carry        = sum_ext[ACC_W];
    cnt_next     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  end

  // The tag pipeline shifts in lockstep with the multiplier registers.
  // The multiplier has no reset, so stale products are never tagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_last  <= '0;
    end else if (mul_ce) begin
      tag_valid[0] <= s_valid & s_ready;
      tag_last[0]  <= s_last & s_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
    end
  end

  // The running burst accumulator, term count and sticky wrap flag.
  // All three clear once the burst's last product has been folded into the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (consume) begin
      if (tag_last[MUL_LAT-1]) begin
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end else begin
        acc    <= sum_ext[ACC_W-1:0];
        cnt    <= cnt_next;
        sticky <= sticky | carry;
      end
    end
  end

  // The result register updates on a last consume and is otherwise held until accepted.
  // A new result may replace an accepted one on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sum      <= '0;
      m_count    <= '0;
      m_overflow <= 1'b0;
      m_valid    <= 1'b0;
    end else if (consume_last) begin
      m_sum      <= sum_ext[ACC_W-1:0];
      m_count    <= cnt_next;
      m_overflow <= sticky | carry;
      m_valid    <= 1'b1;
    end else if (m_ready) begin
      m_valid    <= 1'b0;
    end
  end

endmodule
